div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 23 ++
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared payload types for the DIV pipe: issue-side operands and writeback result.
package div_unit_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        div_op_e     div_control;
    } ix_div_inf_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
    } div_wb_inf_t;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU with a fast path
// for divide-by-zero and signed overflow, and a hold-until-ack writeback port.
module div_unit
    import div_unit_pkg::*;
#(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ix_div_valid,
    input  ix_div_inf_t ix_div,
    output logic        div_ready,
    input  logic        pipeline_flush,
    output logic        div_wb_valid,
    output div_wb_inf_t div_wb,
    input  logic        wb_div_ack
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned LAST_STEP = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvsr;
    div_op_e         op;
    logic            q_sign;
    logic            r_sign;
    logic            special;

    // Issue-side decode of the incoming operands
    logic            accept_c;
    logic            is_signed_c;
    logic            is_rem_in_c;
    logic            div_zero_c;
    logic            ovf_c;
    logic            special_c;
    logic [XLEN-1:0] special_res_c;
    logic [XLEN-1:0] a_abs_c;
    logic [XLEN-1:0] b_abs_c;

    assign accept_c    = ix_div_valid && div_ready && !pipeline_flush;
    assign is_signed_c = (ix_div.div_control == OP_DIV) || (ix_div.div_control == OP_REM);
    assign is_rem_in_c = (ix_div.div_control == OP_REM) || (ix_div.div_control == OP_REMU);
    assign div_zero_c  = (ix_div.rs2 == '0);
    assign ovf_c       = is_signed_c && (ix_div.rs1 == 32'h8000_0000) && (ix_div.rs2 == '1);
    assign special_c   = div_zero_c || ovf_c;
    assign a_abs_c     = (is_signed_c && ix_div.rs1[XLEN-1]) ? XLEN'(-ix_div.rs1) : ix_div.rs1;
    assign b_abs_c     = (is_signed_c && ix_div.rs2[XLEN-1]) ? XLEN'(-ix_div.rs2) : ix_div.rs2;

    always_comb begin
        special_res_c = '0;
        if (div_zero_c) begin
            special_res_c = is_rem_in_c ? ix_div.rs1 : '1;
        end else begin
            special_res_c = is_rem_in_c ? '0 : 32'h8000_0000;
        end
    end

    // One restoring step on the 33-bit partial remainder
    logic [XLEN:0]   shifted_c;
    logic [XLEN:0]   diff_c;
    logic            fits_c;
    logic [XLEN-1:0] step_rem_c;
    logic [XLEN-1:0] step_quo_c;

    assign shifted_c  = {rem, quo[XLEN-1]};
    assign diff_c     = shifted_c - {1'b0, dvsr};
    assign fits_c     = !diff_c[XLEN];
    assign step_rem_c = fits_c ? diff_c[XLEN-1:0] : shifted_c[XLEN-1:0];
    assign step_quo_c = {quo[XLEN-2:0], fits_c};

    // Sign fix-up and result selection applied to the final step
    logic [XLEN-1:0] fixed_q_c;
    logic [XLEN-1:0] fixed_r_c;
    logic [XLEN-1:0] final_c;

    assign fixed_q_c = (q_sign && (op == OP_DIV)) ? XLEN'(-step_quo_c) : step_quo_c;
    assign fixed_r_c = (r_sign && (op == OP_REM)) ? XLEN'(-step_rem_c) : step_rem_c;
    assign final_c   = ((op == OP_REM) || (op == OP_REMU)) ? fixed_r_c : fixed_q_c;

    // div_wb_valid trails entry into DONE by one edge, so ack is only honoured once visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_ready    <= 1'b1;
            div_wb_valid <= 1'b0;
            div_wb       <= '0;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            dvsr         <= '0;
            op           <= OP_DIV;
            q_sign       <= 1'b0;
            r_sign       <= 1'b0;
            special      <= 1'b0;
        end else if (pipeline_flush) begin
            state        <= IDLE;
            div_ready    <= 1'b1;
            div_wb_valid <= 1'b0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        div_wb.rd <= ix_div.rd;
                        op        <= ix_div.div_control;
                        q_sign    <= ix_div.rs1[XLEN-1] ^ ix_div.rs2[XLEN-1];
                        r_sign    <= ix_div.rs1[XLEN-1];
                        rem       <= '0;
                        quo       <= a_abs_c;
                        dvsr      <= b_abs_c;
                        cnt       <= '0;
                        special   <= special_c;
                        div_ready <= 1'b0;
                        if (special_c) begin
                            div_wb.result <= special_res_c;
                        end
                        state <= (special_c && EARLY_OUT) ? DONE : CALC;
                    end
                end
                CALC: begin
                    rem <= step_rem_c;
                    quo <= step_quo_c;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(LAST_STEP)) begin
                        state <= DONE;
                        if (!special) begin
                            div_wb.result <= final_c;
                        end
                    end
                end
                DONE: begin
                    if (div_wb_valid && wb_div_ack) begin
                        state        <= IDLE;
                        div_wb_valid <= 1'b0;
                        div_ready    <= 1'b1;
                    end else begin
                        div_wb_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    div_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: fast-path and full-iteration instances share stimulus.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ix_div_valid;
    ix_div_inf_t ix_div;
    logic        pipeline_flush;
    logic        wb_div_ack;

    logic        ready_f, ready_s;
    logic        valid_f, valid_s;
    div_wb_inf_t wb_f, wb_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.EARLY_OUT(1'b1)) u_dut_fast (
        .clk(clk), .rst_n(rst_n), .ix_div_valid(ix_div_valid), .ix_div(ix_div),
        .div_ready(ready_f), .pipeline_flush(pipeline_flush), .div_wb_valid(valid_f),
        .div_wb(wb_f), .wb_div_ack(wb_div_ack)
    );

    div_unit #(.EARLY_OUT(1'b0)) u_dut_slow (
        .clk(clk), .rst_n(rst_n), .ix_div_valid(ix_div_valid), .ix_div(ix_div),
        .div_ready(ready_s), .pipeline_flush(pipeline_flush), .div_wb_valid(valid_s),
        .div_wb(wb_s), .wb_div_ack(wb_div_ack)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics in plain arithmetic
    function automatic logic [31:0] ref_div(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_DIV:  ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            OP_REM:  ref_div = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            OP_DIVU: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: ref_div = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        is_special = (b == 0) ||
                     ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic issue(input div_op_e op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        ix_div       = '{rd: rd, rs1: a, rs2: b, div_control: op};
        ix_div_valid = 1'b1;
        @(posedge clk); #1;
        ix_div_valid = 1'b0;
    endtask

    task automatic expect_quiet(input int n, input string name);
        bit seen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (valid_f || valid_s) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    // Issue one op, measure latency on both units, optionally hold, then ack (or flush+ack)
    task automatic run_op(input div_op_e op, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold,
                          input bit use_flush, input bit ack_calc, input string name);
        int  lat_f = 0;
        int  lat_s = 0;
        int  k = 0;
        bit  busy_ok = 1'b1;
        bit  hold_ok = 1'b1;
        issue(op, rd, a, b);
        while ((lat_f == 0 || lat_s == 0) && k < 60) begin
            @(posedge clk); #1;
            k++;
            wb_div_ack = 1'b0;
            if (lat_f == 0 && valid_f) lat_f = k;
            if (lat_s == 0 && valid_s) lat_s = k;
            if ((lat_f == 0 && ready_f) || (lat_s == 0 && ready_s)) busy_ok = 1'b0;
            if (ack_calc && k == 4) wb_div_ack = 1'b1;
        end
        wb_div_ack = 1'b0;
        chk({name, ".lat_fast"}, 64'(lat_f), is_special(op, a, b) ? 64'd1 : 64'd33);
        chk({name, ".lat_slow"}, 64'(lat_s), 64'd33);
        chk({name, ".busy"}, 64'(busy_ok), 64'd1);
        chk({name, ".res_fast"}, 64'(wb_f.result), 64'(exp));
        chk({name, ".res_slow"}, 64'(wb_s.result), 64'(exp));
        chk({name, ".rd"}, {32'(wb_f.rd), 32'(wb_s.rd)}, {32'(rd), 32'(rd)});
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                if (wb_f.result !== exp || wb_s.result !== exp || wb_f.rd !== rd ||
                    !valid_f || !valid_s || ready_f || ready_s) hold_ok = 1'b0;
            end
            chk({name, ".hold"}, 64'(hold_ok), 64'd1);
        end
        wb_div_ack     = 1'b1;
        pipeline_flush = use_flush;
        @(posedge clk); #1;
        wb_div_ack     = 1'b0;
        pipeline_flush = 1'b0;
        chk({name, ".after_ack"}, {ready_f, ready_s, valid_f, valid_s}, 64'b1100);
    endtask

    typedef struct {
        div_op_e     op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{OP_DIV,  5'd5,  32'd100,        32'd7,          32'd14,         "div_100_7"};
        vecs[1]  = '{OP_REM,  5'd1,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "rem_m7_2"};
        vecs[2]  = '{OP_DIVU, 5'd2,  32'hFFFF_FFFE,  32'd2,          32'h7FFF_FFFF,  "divu_big_2"};
        vecs[3]  = '{OP_DIV,  5'd3,  32'd12345,      32'd0,          32'hFFFF_FFFF,  "div_by0"};
        vecs[4]  = '{OP_REMU, 5'd4,  32'd9,          32'd0,          32'd9,          "remu_9_0"};
        vecs[5]  = '{OP_DIV,  5'd6,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf"};
        vecs[6]  = '{OP_REM,  5'd7,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "rem_ovf"};
        vecs[7]  = '{OP_DIVU, 5'd8,  32'd7,          32'd0,          32'hFFFF_FFFF,  "divu_by0"};
        vecs[8]  = '{OP_REM,  5'd9,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  "rem_m7_0"};
        vecs[9]  = '{OP_DIV,  5'd10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  "div_m100_7"};
        vecs[10] = '{OP_REMU, 5'd11, 32'd100,        32'd7,          32'd2,          "remu_100_7"};
        vecs[11] = '{OP_DIV,  5'd0,  32'd9,          32'd3,          32'd3,          "div_rd0"};
        vecs[12] = '{OP_DIVU, 5'd31, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "divu_nofix"};

        rst_n = 1'b0; ix_div_valid = 1'b0; ix_div = '0; pipeline_flush = 1'b0; wb_div_ack = 1'b0;
        #12;
        chk("reset_ctl", {ready_f, ready_s, valid_f, valid_s}, 64'b1100);
        chk("reset_wb", {27'(0), wb_f, 32'(0)} | 64'(wb_s), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1'b0, 1'b0, vecs[i].name);

        // Long hold without ack, then back-to-back issue right after the ack
        run_op(OP_DIV, 5'd12, 32'd1000, 32'd33, 32'd30, 10, 1'b0, 1'b0, "hold10");
        run_op(OP_REMU, 5'd13, 32'd1000, 32'd33, 32'd10, 0, 1'b0, 1'b0, "b2b");

        // Ack while nothing is valid is ignored
        run_op(OP_DIV, 5'd14, 32'd77, 32'd11, 32'd7, 0, 1'b0, 1'b1, "ack_in_calc");

        // Flush mid-CALC aborts silently
        issue(OP_DIV, 5'd15, 32'd500, 32'd5);
        repeat (14) @(posedge clk);
        #1 pipeline_flush = 1'b1;
        @(posedge clk); #1;
        pipeline_flush = 1'b0;
        chk("flush_calc", {ready_f, ready_s, valid_f, valid_s}, 64'b1100);
        expect_quiet(40, "flush_calc.quiet");
        run_op(OP_DIV, 5'd16, 32'd9, 32'd3, 32'd3, 0, 1'b0, 1'b0, "post_flush");

        // Flush together with ack in DONE
        run_op(OP_REM, 5'd17, 32'd50, 32'd7, 32'd1, 0, 1'b1, 1'b0, "flush_ack");

        // Issue coinciding with flush is dropped
        ix_div = '{rd: 5'd18, rs1: 32'd8, rs2: 32'd0, div_control: OP_DIV};
        ix_div_valid = 1'b1; pipeline_flush = 1'b1;
        @(posedge clk); #1;
        ix_div_valid = 1'b0; pipeline_flush = 1'b0;
        chk("issue_flush", {ready_f, ready_s}, 64'b11);
        expect_quiet(40, "issue_flush.quiet");

        // Asynchronous reset between edges mid-CALC
        issue(OP_DIVU, 5'd19, 32'd999, 32'd4);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", {ready_f, ready_s, valid_f, valid_s}, 64'b1100);
        chk("async_rst_wb", 64'(wb_f) | 64'(wb_s), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        expect_quiet(40, "async_rst.quiet");
        run_op(OP_DIVU, 5'd20, 32'd999, 32'd4, 32'd249, 0, 1'b0, 1'b0, "post_rst");

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            div_op_e     op;
            logic [31:0] a, b;
            int          sel;
            op  = div_op_e'($urandom_range(0, 3));
            a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 9);
            b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
                  (sel == 2) ? 32'($urandom_range(1, 16)) : $urandom;
            run_op(op, 5'($urandom_range(0, 31)), a, b, ref_div(op, a, b), 0, 1'b0, 1'b0,
                   $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
